mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single external memory port between the instruction-cache and data-cache
//  controllers. Grants one requester at a time and runs a whole cache-block burst
//  (read refill or data write) word by word. Returns each word plus a one-cycle done
//  pulse to the granted cache, so each cache controller only holds a request and stalls.
// PARAMETERS
//  BLOCKWORDS  4   words per cache block; power of two, >=2
//  AW          32  byte-address width
//  DW          32  word width
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          asynchronous, active-low reset
//  i_req        in   1          icache requests block read; held until i_done
//  i_addr       in   AW         icache block address (low offset bits ignored)
//  i_rdata      out  DW         read word to icache; valid when i_wordvalid
//  i_wordvalid  out  1          one word of i burst completed this cycle
//  i_wordidx    out  log2(BW)   index of the word in flight for icache
//  i_done       out  1          1-cycle pulse: icache burst complete
//  d_req        in   1          dcache request; held until d_done
//  d_we         in   1          1 = block write, 0 = block read; stable while d_req
//  d_addr       in   AW         dcache block address
//  d_wdata      in   DW         write word for current d_wordidx (combinational)
//  d_rdata      out  DW         read word to dcache; valid when d_wordvalid
//  d_wordvalid  out  1          one word of d burst completed this cycle
//  d_wordidx    out  log2(BW)   index of the word in flight for dcache
//  d_done       out  1          1-cycle pulse: dcache burst complete
//  m_en         out  1          memory access active this cycle
//  m_we         out  1          memory write strobe (qualified by m_en)
//  m_addr       out  AW         word address {blk, cnt, 2'b00}
//  m_wdata      out  DW         = d_wdata while granted D write, else 0
//  m_rdata      in   DW         memory read data, valid with m_ready
//  m_ready      in   1          memory accepts/completes current word this cycle
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, cnt=0, lastgnt=I, so D wins the
//    first tie. Every output is 0 during reset and in IDLE.
//  - States: IDLE -> BURST -> DONE -> IDLE.
//  - IDLE: if exactly one req, grant it. If both, grant the one not in lastgnt
//    (round-robin). Latch gnt, the block address and we; cnt=0; go to BURST.
//    Neither req: stay in IDLE.
//  - BURST: m_en=1, m_we=(gnt==D)&we, m_addr={blk[AW-1:log2(BW)+2], cnt, 2'b00}.
//    Each cycle with m_ready: the granted *_wordvalid=1, *_rdata=m_rdata, cnt++.
//    On m_ready with cnt==BW-1, go to DONE. Without m_ready, hold all outputs (wait).
//  - DONE: the granted *_done=1 for exactly one cycle; lastgnt<=gnt; cnt=0; go to IDLE.
//    Requester drops req on the edge after done, so IDLE never re-grants a finished
//    request. Minimum gap between bursts: 1 IDLE cycle.
//  - Ungranted side: *_wordvalid, *_done, *_rdata all 0. *_wordidx tracks cnt only
//    for the granted side, else 0.
//  - A req deasserted mid-burst is ignored: the burst completes and done still pulses.
//    A new req during BURST/DONE waits for IDLE.
//  - Latency: single-cycle memory (m_ready=1) gives BW+2 cycles from req sampled in
//    IDLE to done.
//  - cnt is log2(BW) bits and wraps only at DONE. Address offset bits come from cnt,
//    never from *_addr low bits.
//  - Reset mid-burst aborts immediately: no done pulse, m_en=0, lastgnt=I.
// STRUCTURE
//  - mem_arb_pkg: typedef enum logic [1:0] {IDLE, BURST, DONE} arbstate_t;
//    typedef enum logic {GNT_I, GNT_D} gnt_t; function clog2 for width math.
//  - Sub-module arb_burst_counter: cnt register with clear/inc/last flag,
//    parameter BLOCKWORDS.
//  - Top: FSM, round-robin bit, address/we latch, output steering muxes.
// TESTING
//  1 Reset: reset=0 mid-burst, then release -> all outputs 0, IDLE; next tie grants D.
//  2 i_req only, addr 0x1004, m_ready=1 -> m_addr 0x1000,0x1004,0x1008,0x100C;
//    i_wordvalid x4; i_done on cycle 6.
//  3 d write, addr 0x2000, d_wdata=0xA0+idx -> m_we=1 and m_wdata A0..A3 at
//    0x2000..0x200C; d_done 1 cycle.
//  4 i_req & d_req together from reset -> D burst, then I burst; next tie -> D;
//    no gap >1 IDLE cycle.
//  5 m_ready low 3 cycles at word 2 -> m_addr/cnt held, no wordvalid; resumes; total BW+5.
//  6 d_req dropped after word 1 -> burst still finishes, d_done pulses; i_req then granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and helpers for the memory port arbiter.
//   arbstate_t : arbiter FSM states (IDLE -> BURST -> DONE -> IDLE)
//   gnt_t      : which cache currently owns the memory port
//   clog2      : elaboration-time ceil(log2(n)) used for counter/index widths
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BURST, DONE} arbstate_t;

  typedef enum logic {GNT_I, GNT_D} gnt_t;

  // Smallest r with 2**r >= n; evaluated only on parameters.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// arb_burst_counter
//   Word counter for one cache-block burst.
//   Ports:
//     clk, reset : rising-edge clock, asynchronous active-low reset
//     i_clear    : force the count back to 0 (has priority over i_inc)
//     i_inc      : advance to the next word
//     o_cnt      : index of the word currently in flight
//     o_last     : high while the final word of the block is in flight
module arb_burst_counter
  import mem_arb_pkg::*;
#(
  parameter int BLOCKWORDS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_clear,
  input  logic                          i_inc,
  output logic [clog2(BLOCKWORDS)-1:0]  o_cnt,
  output logic                          o_last
);

  localparam int CW = clog2(BLOCKWORDS);

  logic [CW-1:0] r_cnt;

  // The count is a plain power-of-two wrap; clearing wins so the arbiter can
  // park it at zero while idle or while pulsing done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == CW'(BLOCKWORDS - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between the icache and dcache controllers.
//   One requester is granted at a time (round-robin on ties) and a whole block
//   burst is run word by word, returning each word and a one-cycle done pulse.
//   Ports:
//     clk, reset        : rising-edge clock, asynchronous active-low reset
//     i_req/i_addr      : icache block-read request and block address
//     i_rdata/i_wordvalid/i_wordidx/i_done : per-word return to the icache
//     d_req/d_we/d_addr/d_wdata : dcache request, direction, address, write word
//     d_rdata/d_wordvalid/d_wordidx/d_done : per-word return to the dcache
//     m_en/m_we/m_addr/m_wdata : memory-side command for the word in flight
//     m_rdata/m_ready   : memory read data and per-word completion
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLOCKWORDS = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_req,
  input  logic [AW-1:0]                 i_addr,
  output logic [DW-1:0]                 i_rdata,
  output logic                          i_wordvalid,
  output logic [clog2(BLOCKWORDS)-1:0]  i_wordidx,
  output logic                          i_done,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [AW-1:0]                 d_addr,
  input  logic [DW-1:0]                 d_wdata,
  output logic [DW-1:0]                 d_rdata,
  output logic                          d_wordvalid,
  output logic [clog2(BLOCKWORDS)-1:0]  d_wordidx,
  output logic                          d_done,
  output logic                          m_en,
  output logic                          m_we,
  output logic [AW-1:0]                 m_addr,
  output logic [DW-1:0]                 m_wdata,
  input  logic [DW-1:0]                 m_rdata,
  input  logic                          m_ready
);

  localparam int CW   = clog2(BLOCKWORDS);
  localparam int BLKW = AW - CW - 2;

  arbstate_t       r_state;
  arbstate_t       w_nextState;
  gnt_t            r_gnt;
  gnt_t            r_lastGnt;
  gnt_t            w_selGnt;
  logic [BLKW-1:0] r_blk;
  logic            r_we;
  logic            w_load;
  logic            w_clear;
  logic            w_inc;
  logic            w_last;
  logic [CW-1:0]   w_cnt;
  logic            w_unused;

  // Word-offset and byte-offset bits of the request addresses are replaced
  // by the burst counter, so they are intentionally dropped here.
  assign w_unused = ^{i_addr[CW+1:0], d_addr[CW+1:0]};

  arb_burst_counter #(
    .BLOCKWORDS(BLOCKWORDS)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .o_cnt   (w_cnt),
    .o_last  (w_last)
  );

  // State register; an asynchronous reset aborts any burst without a done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Grant bookkeeping. The block address and direction are captured at grant
  // time so requesters may change their inputs once the burst is underway.
  // lastGnt resets to I so that the very first tie goes to the dcache.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt     <= GNT_I;
      r_lastGnt <= GNT_I;
      r_blk     <= '0;
      r_we      <= 1'b0;
    end else begin
      if (w_load) begin
        r_gnt <= w_selGnt;
        r_blk <= (w_selGnt == GNT_D) ? d_addr[AW-1:CW+2] : i_addr[AW-1:CW+2];
        r_we  <= (w_selGnt == GNT_D) && d_we;
      end
      if (r_state == DONE) begin
        r_lastGnt <= r_gnt;
      end
    end
  end

  // Next state plus all output steering. Every output defaults to zero, so the
  // ungranted side and the IDLE state stay quiet; only the granted side sees
  // word index, word strobes, read data and done.
  always_comb begin
    w_nextState = r_state;
    w_selGnt    = r_gnt;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_inc       = 1'b0;
    m_en        = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    i_rdata     = '0;
    i_wordvalid = 1'b0;
    i_wordidx   = '0;
    i_done      = 1'b0;
    d_rdata     = '0;
    d_wordvalid = 1'b0;
    d_wordidx   = '0;
    d_done      = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (i_req || d_req) begin
          w_load      = 1'b1;
          w_nextState = BURST;
          if (i_req && d_req) begin
            w_selGnt = (r_lastGnt == GNT_I) ? GNT_D : GNT_I;
          end else begin
            w_selGnt = d_req ? GNT_D : GNT_I;
          end
        end
      end

      BURST: begin
        m_en   = 1'b1;
        m_we   = (r_gnt == GNT_D) && r_we;
        m_addr = {r_blk, w_cnt, 2'b00};
        if (m_we) begin
          m_wdata = d_wdata;
        end
        if (r_gnt == GNT_D) begin
          d_wordidx = w_cnt;
        end else begin
          i_wordidx = w_cnt;
        end
        if (m_ready) begin
          w_inc = 1'b1;
          if (r_gnt == GNT_D) begin
            d_wordvalid = 1'b1;
            d_rdata     = m_rdata;
          end else begin
            i_wordvalid = 1'b1;
            i_rdata     = m_rdata;
          end
          if (w_last) begin
            w_nextState = DONE;
          end
        end
      end

      DONE: begin
        w_clear     = 1'b1;
        w_nextState = IDLE;
        if (r_gnt == GNT_D) begin
          d_done = 1'b1;
        end else begin
          i_done = 1'b1;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule
